// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared constants for the keypad matrix scanner
package keypad_scanner_pkg;

  localparam int KEY_CODE_W         = 8;
  localparam int DEF_SCAN_DIVIDER   = 14;
  localparam int DEF_DEBOUNCE_SCANS = 4;

  localparam logic [0:0] KS_RELEASED = 1'b0;
  localparam logic [0:0] KS_PRESSED  = 1'b1;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - whole-matrix frame comparison and debounced image register
module keypad_debounce import keypad_scanner_pkg::*; #(
  parameter int N              = 16,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] frame_img,
  input  logic         frame_end,
  output logic [N-1:0] deb_next,
  output logic         image_changed
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [N-1:0]  prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  deb_q, deb_d;

  // deb_d is exported so the reporting logic reacts in the same cycle the image is accepted
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (frame_end) begin
      prev_d = frame_img;
      if (frame_img != prev_q)
        cnt_d = '0;
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + CW'(1);
      if (cnt_d == CNT_MAX)
        deb_d = frame_img;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_next      = deb_d;
  assign image_changed = (deb_d != deb_q);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row-scanned key matrix with debounce and valid/ack key reporting
module keypad_scanner import keypad_scanner_pkg::*; #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIVIDER   = DEF_SCAN_DIVIDER,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [ROWS-1:0]       KEY_ROW,
  input  logic [COLS-1:0]       KEY_COL,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ack,
  output logic                  key_down,
  output logic                  overrun
);

  localparam int                      N        = ROWS * COLS;
  localparam int                      RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0]           ROW_LAST = RW'(ROWS - 1);
  localparam logic [SCAN_DIVIDER-1:0] PRESC_1  = SCAN_DIVIDER'(1);

  logic [COLS-1:0]         col_meta_q, col_sync_q;
  logic [SCAN_DIVIDER-1:0] presc_q, presc_d;
  logic [RW-1:0]           row_q, row_d;
  logic [N-1:0]            frame_q, frame_d;
  logic [0:0]              state_q, state_d;
  key_code_t               code_q, code_d, press_code;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    key_down_q, key_down_d;
  logic                    tick, frame_end, press_event, image_changed;
  logic [N-1:0]            deb_next;

  assign tick      = &presc_q;
  assign frame_end = tick && (row_q == ROW_LAST);

  always_comb begin
    presc_d = presc_q + PRESC_1;
    row_d   = row_q;
    frame_d = frame_q;
    if (tick) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      for (int r = 0; r < ROWS; r++)
        if (row_q == RW'(r)) frame_d[r*COLS +: COLS] = col_sync_q;
    end
  end

  always_comb begin
    KEY_ROW = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_q == RW'(r)) KEY_ROW[r] = 1'b1;
  end

  // frame_d carries the slot written on this tick, so the debouncer sees the completed frame
  keypad_debounce #(.N(N), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk          (CLK),
    .rst          (RST),
    .frame_img    (frame_d),
    .frame_end    (frame_end),
    .deb_next     (deb_next),
    .image_changed(image_changed)
  );

  // descending scan so the lowest flat index is the last assignment
  always_comb begin
    press_code = '0;
    for (int i = N - 1; i >= 0; i--)
      if (deb_next[i]) press_code = KEY_CODE_W'(i);
  end

  assign press_event = (state_q == KS_RELEASED) && image_changed && (|deb_next);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    key_down_d = |deb_next;
    if (image_changed)
      state_d = (|deb_next) ? KS_PRESSED : KS_RELEASED;
    if (valid_q && key_ack) begin
      overrun_d = 1'b0;
      if (press_event) code_d = press_code;
      else             valid_d = 1'b0;
    end else if (press_event) begin
      if (valid_q) begin
        overrun_d = 1'b1;
      end else begin
        code_d  = press_code;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col_meta_q <= '0;
      col_sync_q <= '0;
      presc_q    <= '0;
      row_q      <= '0;
      frame_q    <= '0;
      state_q    <= KS_RELEASED;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      col_meta_q <= KEY_COL;
      col_sync_q <= col_meta_q;
      presc_q    <= presc_d;
      row_q      <= row_d;
      frame_q    <= frame_d;
      state_q    <= state_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      key_down_q <= key_down_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign overrun   = overrun_q;
  assign key_down  = key_down_q;

endmodule
